l1_dma_engine: RTL and testbench
================================

// Module: l1_dma_engine
// PURPOSE
//  AXI4 burst master feeding the L1 memories: it drives the dma_* ports of inst_mem and data_mem.
//  Refill: AXI read burst -> writes into inst_mem or data_mem.
//  Writeback: reads data_mem -> AXI write burst.
//  One command at a time; the miss/hit controller issues commands and waits for done.
// PARAMETERS
//  DATA_WIDTH       32  AXI and memory word width (bytes/beat = DATA_WIDTH/8)
//  ADDR_WIDTH       32  AXI address and local byte-address width
//  READ_BURST_LEN   8   beats per refill (arlen = READ_BURST_LEN-1)
//  WRITE_BURST_LEN  8   beats per writeback (awlen = WRITE_BURST_LEN-1)
// PORTS
//  cpu_clk               in   1   single clock
//  cpu_rst               in   1   asynchronous, active-high reset
//  cmd_valid/cmd_ready   in/out 1 command handshake; accepted when both high
//  cmd_op                in   2   0=refill inst, 1=refill data, 2=writeback data, 3=reserved
//  cmd_local_addr        in   AW  local byte address of first word (word-aligned)
//  cmd_ext_addr          in   AW  AXI byte address of first beat
//  done                  out  1   1-cycle pulse at command end
//  err                   out  1   valid with done: any non-OKAY resp, rlast mismatch, or op 3
//  dma_inst_mem_waddr/wdata  out AW/DW  inst_mem write port
//  inst_mem_write            out 1      inst_mem write enable
//  dma_data_mem_raddr        out AW     data_mem read address
//  data_mem_rdata            in  DW     data_mem read data, combinational from raddr
//  data_mem_read_ctrl_by     out 1      1 = DMA owns data_mem read port
//  dma_data_mem_waddr/wdata  out AW/DW  data_mem write port
//  data_mem_write            out 1      data_mem write enable (DMA side)
//  data_mem_write_ctrl_by    out 1      1 = DMA owns data_mem write port
//  m_axi_ar{addr,len[8],size[3],burst[2],valid}/arready   AXI read address
//  m_axi_r{data,resp[2],last,valid}/rready                AXI read data
//  m_axi_aw{addr,len[8],size[3],burst[2],valid}/awready   AXI write address
//  m_axi_w{data,strb[DW/8],last,valid}/wready             AXI write data
//  m_axi_b{resp[2],valid}/bready                          AXI write response
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; all valids, write enables, ctrl_by, done, err=0; addresses/data=0.
//  States: IDLE->AR->R->DONE (refill); IDLE->AW->W->B->DONE (writeback); op 3: IDLE->DONE, err=1.
//  IDLE: cmd_ready=1; on accept, latch op and addrs, clear beat count and err, cmd_ready drops next cycle.
//  AR: arvalid=1, araddr=ext addr; size=log2(DW/8), burst=INCR(01); leave on arvalid&arready.
//  R: rready=1; each rvalid beat writes rdata the same cycle to local_addr+4*beat (comb enable = rvalid&rready).
//   rresp!=0 -> sticky err.
//   rlast on beat READ_BURST_LEN-1 -> DONE.
//   rlast early or missing on last beat -> err=1, go to DONE at rlast; never write past burst length.
//  Refill data: data_mem_write_ctrl_by=1 from accept through DONE.
//  Refill inst: inst_mem_write only; data_mem untouched.
//  AW: awvalid=1 until awready; data_mem_read_ctrl_by=1 from accept through DONE.
//  W: wvalid=1; dma_data_mem_raddr=local_addr+4*beat; wdata=data_mem_rdata; wstrb all ones.
//   wlast=(beat==WRITE_BURST_LEN-1); beat advances only on wvalid&wready; wdata held stable while stalled.
//  AW and W are sequential: no W beat before AW handshake.
//  B: bready=1; on bvalid, bresp!=0 -> err=1; -> DONE.
//  DONE: done=1 for one cycle, err valid; ctrl_by released; next state IDLE.
//  cmd_valid while busy: ignored (cmd_ready=0); no queueing.
//  Beat counter width clog2(max burst)+1; local/ext address arithmetic modulo 2^AW (wrap allowed, no check).
//  Reset mid-burst: immediate return to reset values; AXI transaction is abandoned (system-level reset assumed).
//  Throughput: one beat per cycle when slave is always ready; refill latency = 1(AR)+N beats+1(DONE).
// STRUCTURE
//  Package l1_pkg: op codes (OP_REFILL_I/OP_REFILL_D/OP_WB_D), AXI_BURST_INCR, AXI_RESP_OKAY, state enum encoding.
//  Single module, with no sub-modules.
//  l1_dma_engine is instantiated in L1_cache, replacing the tied-off dma_* connections.
// TESTING
//  1. Refill inst, local 0x40, ext 0x1000, slave returns 8 beats 0xA0..A7, always ready
//     -> inst_mem writes 0x40..0x5C = A0..A7, done at cycle 10, err=0.
//  2. Refill data with random rvalid gaps
//     -> exactly 8 data_mem writes, ctrl_by high throughout, no writes on idle cycles.
//  3. Writeback local 0x20, mem preloaded 0..7, wready toggles every other cycle
//     -> wdata 0..7 in order, wlast only on beat 7, bresp OKAY -> done, err=0.
//  4. rresp=SLVERR on beat 3, or bresp=DECERR
//     -> full burst still consumed, done with err=1.
//  5. rlast asserted on beat 5
//     -> err=1, 6 writes only, done.
//     Separately, cmd_valid during busy -> ignored, cmd_ready=0.
//  6. cpu_rst asserted mid-W
//     -> next edge: IDLE, wvalid/awvalid/ctrl_by=0, cmd_ready=1.
//     A new refill after reset completes correctly.

Source files
------------

// File: rtl/l1_pkg.sv
// Shared definitions for the L1 DMA engine: command opcodes,
// AXI encodings and the controller state encoding.
package l1_pkg;

    typedef enum logic [1:0] {
        OP_REFILL_I = 2'd0,
        OP_REFILL_D = 2'd1,
        OP_WB_D     = 2'd2,
        OP_RSVD     = 2'd3
    } dma_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } dma_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/l1_dma_engine.sv
// AXI4 burst master for the L1 memories: refills inst_mem/data_mem
// from AXI read bursts and writes data_mem back with AXI write bursts.
module l1_dma_engine
    import l1_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_local_addr,
    input  logic [ADDR_WIDTH-1:0]   cmd_ext_addr,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   dma_inst_mem_waddr,
    output logic [DATA_WIDTH-1:0]   dma_inst_mem_wdata,
    output logic                    inst_mem_write,
    output logic [ADDR_WIDTH-1:0]   dma_data_mem_raddr,
    input  logic [DATA_WIDTH-1:0]   data_mem_rdata,
    output logic                    data_mem_read_ctrl_by,
    output logic [ADDR_WIDTH-1:0]   dma_data_mem_waddr,
    output logic [DATA_WIDTH-1:0]   dma_data_mem_wdata,
    output logic                    data_mem_write,
    output logic                    data_mem_write_ctrl_by,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int MAXB  = (READ_BURST_LEN > WRITE_BURST_LEN) ?
                           READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int BW    = $clog2(MAXB) + 1;

    localparam logic [BW-1:0] R_LAST = BW'(READ_BURST_LEN - 1);
    localparam logic [BW-1:0] R_END  = BW'(READ_BURST_LEN);
    localparam logic [BW-1:0] W_LAST = BW'(WRITE_BURST_LEN - 1);

    dma_state_e            state_q, state_d;
    dma_op_e               op_q;
    logic [ADDR_WIDTH-1:0] local_q;
    logic [ADDR_WIDTH-1:0] ext_q;
    logic [BW-1:0]         beat_q;
    logic                  err_q;

    logic                  accept;
    logic                  r_fire;
    logic                  r_in;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign r_fire    = (state_q == ST_R) && m_axi_rvalid;
    assign r_in      = beat_q < R_END;
    assign w_fire    = (state_q == ST_W) && m_axi_wready;
    assign word_addr = local_q
                     + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BYTES);

    assign m_axi_arlen   = 8'(READ_BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(BYTES));
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_awlen   = 8'(WRITE_BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(BYTES));
    assign m_axi_awburst = AXI_BURST_INCR;

    // State register
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Command latch, beat counter and sticky error flag
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            op_q    <= OP_REFILL_I;
            local_q <= '0;
            ext_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= dma_op_e'(cmd_op);
                local_q <= cmd_local_addr;
                ext_q   <= cmd_ext_addr;
                beat_q  <= '0;
                err_q   <= (cmd_op == OP_RSVD);
            end
            if (r_fire) begin
                if (r_in)
                    beat_q <= beat_q + 1'b1;
                if (m_axi_rresp != AXI_RESP_OKAY)
                    err_q <= 1'b1;
                // rlast must coincide exactly with the final beat
                if (m_axi_rlast ? (beat_q != R_LAST) : (beat_q >= R_LAST))
                    err_q <= 1'b1;
            end
            if (w_fire)
                beat_q <= beat_q + 1'b1;
            if ((state_q == ST_B) && m_axi_bvalid
                && (m_axi_bresp != AXI_RESP_OKAY))
                err_q <= 1'b1;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d                = state_q;
        cmd_ready              = 1'b0;
        done                   = 1'b0;
        err                    = 1'b0;
        m_axi_araddr           = '0;
        m_axi_arvalid          = 1'b0;
        m_axi_rready           = 1'b0;
        m_axi_awaddr           = '0;
        m_axi_awvalid          = 1'b0;
        m_axi_wdata            = '0;
        m_axi_wstrb            = '0;
        m_axi_wlast            = 1'b0;
        m_axi_wvalid           = 1'b0;
        m_axi_bready           = 1'b0;
        dma_inst_mem_waddr     = '0;
        dma_inst_mem_wdata     = '0;
        inst_mem_write         = 1'b0;
        dma_data_mem_waddr     = '0;
        dma_data_mem_wdata     = '0;
        data_mem_write         = 1'b0;
        dma_data_mem_raddr     = '0;
        data_mem_write_ctrl_by = (state_q != ST_IDLE) && (op_q == OP_REFILL_D);
        data_mem_read_ctrl_by  = (state_q != ST_IDLE) && (op_q == OP_WB_D);
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    unique case (dma_op_e'(cmd_op))
                        OP_REFILL_I, OP_REFILL_D: state_d = ST_AR;
                        OP_WB_D:                  state_d = ST_AW;
                        default:                  state_d = ST_DONE;
                    endcase
                end
            end
            ST_AR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = ext_q;
                if (m_axi_arready) state_d = ST_R;
            end
            ST_R: begin
                m_axi_rready = 1'b1;
                if (op_q == OP_REFILL_I) begin
                    dma_inst_mem_waddr = word_addr;
                    dma_inst_mem_wdata = m_axi_rdata;
                    inst_mem_write     = r_fire && r_in;
                end else begin
                    dma_data_mem_waddr = word_addr;
                    dma_data_mem_wdata = m_axi_rdata;
                    data_mem_write     = r_fire && r_in;
                end
                if (r_fire && m_axi_rlast) state_d = ST_DONE;
            end
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                m_axi_awaddr  = ext_q;
                if (m_axi_awready) state_d = ST_W;
            end
            ST_W: begin
                m_axi_wvalid       = 1'b1;
                dma_data_mem_raddr = word_addr;
                m_axi_wdata        = data_mem_rdata;
                m_axi_wstrb        = '1;
                m_axi_wlast        = (beat_q == W_LAST);
                if (w_fire && (beat_q == W_LAST)) state_d = ST_B;
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_l1_dma_engine.sv
// Directed bench for l1_dma_engine: a behavioural AXI slave and
// L1 memory model driven step by step from one initial block.
module tb_l1_dma_engine;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_local_addr;
    logic [31:0] cmd_ext_addr;
    logic        done;
    logic        err;
    logic [31:0] dma_inst_mem_waddr;
    logic [31:0] dma_inst_mem_wdata;
    logic        inst_mem_write;
    logic [31:0] dma_data_mem_raddr;
    logic [31:0] data_mem_rdata;
    logic        data_mem_read_ctrl_by;
    logic [31:0] dma_data_mem_waddr;
    logic [31:0] dma_data_mem_wdata;
    logic        data_mem_write;
    logic        data_mem_write_ctrl_by;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dmem_pre [0:255];
    logic [31:0] imem_log [0:255];
    logic [31:0] dmem_log [0:255];
    int iw_cnt  = 0;
    int dw_cnt  = 0;
    int bad_cnt = 0;

    l1_dma_engine dut (
        .cpu_clk                (cpu_clk),
        .cpu_rst                (cpu_rst),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_op                 (cmd_op),
        .cmd_local_addr         (cmd_local_addr),
        .cmd_ext_addr           (cmd_ext_addr),
        .done                   (done),
        .err                    (err),
        .dma_inst_mem_waddr     (dma_inst_mem_waddr),
        .dma_inst_mem_wdata     (dma_inst_mem_wdata),
        .inst_mem_write         (inst_mem_write),
        .dma_data_mem_raddr     (dma_data_mem_raddr),
        .data_mem_rdata         (data_mem_rdata),
        .data_mem_read_ctrl_by  (data_mem_read_ctrl_by),
        .dma_data_mem_waddr     (dma_data_mem_waddr),
        .dma_data_mem_wdata     (dma_data_mem_wdata),
        .data_mem_write         (data_mem_write),
        .data_mem_write_ctrl_by (data_mem_write_ctrl_by),
        .m_axi_araddr           (m_axi_araddr),
        .m_axi_arlen            (m_axi_arlen),
        .m_axi_arsize           (m_axi_arsize),
        .m_axi_arburst          (m_axi_arburst),
        .m_axi_arvalid          (m_axi_arvalid),
        .m_axi_arready          (m_axi_arready),
        .m_axi_rdata            (m_axi_rdata),
        .m_axi_rresp            (m_axi_rresp),
        .m_axi_rlast            (m_axi_rlast),
        .m_axi_rvalid           (m_axi_rvalid),
        .m_axi_rready           (m_axi_rready),
        .m_axi_awaddr           (m_axi_awaddr),
        .m_axi_awlen            (m_axi_awlen),
        .m_axi_awsize           (m_axi_awsize),
        .m_axi_awburst          (m_axi_awburst),
        .m_axi_awvalid          (m_axi_awvalid),
        .m_axi_awready          (m_axi_awready),
        .m_axi_wdata            (m_axi_wdata),
        .m_axi_wstrb            (m_axi_wstrb),
        .m_axi_wlast            (m_axi_wlast),
        .m_axi_wvalid           (m_axi_wvalid),
        .m_axi_wready           (m_axi_wready),
        .m_axi_bresp            (m_axi_bresp),
        .m_axi_bvalid           (m_axi_bvalid),
        .m_axi_bready           (m_axi_bready)
    );

    always #5 cpu_clk = ~cpu_clk;

    // data_mem read port is combinational from the address
    assign data_mem_rdata = dmem_pre[dma_data_mem_raddr[9:2]];

    // Memory-side monitor: log every write and flag illegal ones
    always @(posedge cpu_clk) begin
        if (inst_mem_write) begin
            imem_log[dma_inst_mem_waddr[9:2]] <= dma_inst_mem_wdata;
            iw_cnt <= iw_cnt + 1;
        end
        if (data_mem_write) begin
            dmem_log[dma_data_mem_waddr[9:2]] <= dma_data_mem_wdata;
            dw_cnt <= dw_cnt + 1;
        end
        if ((data_mem_write && (!data_mem_write_ctrl_by || !m_axi_rvalid))
            || (inst_mem_write && !m_axi_rvalid))
            bad_cnt <= bad_cnt + 1;
    end

    // Hard time limit so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a refill and act as the AXI read slave.
    task automatic run_read(
        input  logic [1:0]  op,
        input  logic [31:0] la,
        input  logic [31:0] ea,
        input  int          nbeats,
        input  int          last_at,
        input  int          err_at,
        input  bit          gaps,
        input  bit          poke,
        input  logic [7:0]  base,
        output int          cyc,
        output bit          got_done,
        output bit          got_err,
        output int          busy_bad
    );
        int w;
        busy_bad = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_local_addr = la;
        cmd_ext_addr = ea;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        cyc = 1;
        w = 0;
        while (!m_axi_arvalid && w < 20) begin
            step();
            cyc++;
            w++;
        end
        chk("ar_valid", m_axi_arvalid, 1'b1);
        chk("ar_addr", m_axi_araddr, ea);
        chk("ar_len_size_burst",
            {m_axi_arlen, m_axi_arsize, m_axi_arburst},
            {8'd7, 3'd2, 2'b01});
        step();
        cyc++;
        for (int i = 0; i < nbeats; i++) begin
            for (int g = 0; g < (gaps ? (i % 3) : 0); g++) begin
                m_axi_rvalid = 1'b0;
                #1;
                if (data_mem_write || inst_mem_write) busy_bad++;
                if (op == 2'd1 && !data_mem_write_ctrl_by) busy_bad++;
                step();
                cyc++;
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata = {24'h0, base + 8'(i)};
            m_axi_rresp = (i == err_at) ? 2'b10 : 2'b00;
            m_axi_rlast = (i == last_at);
            if (poke && i == 1) begin
                cmd_valid = 1'b1;
                cmd_op = 2'd2;
            end
            if (poke && i == 3) cmd_valid = 1'b0;
            #1;
            if (!m_axi_rready) busy_bad++;
            if (cmd_valid && cmd_ready) busy_bad++;
            if (op == 2'd1 && !data_mem_write_ctrl_by) busy_bad++;
            step();
            cyc++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
        cmd_valid = 1'b0;
        got_done = done;
        got_err = err;
        step();
    endtask

    // Issue a writeback and act as the AXI write slave.
    task automatic run_wb(
        input  logic [31:0] la,
        input  logic [31:0] ea,
        input  bit          toggle,
        input  logic [1:0]  bresp,
        input  int          stop_after,
        output bit          got_done,
        output bit          got_err,
        output int          data_bad,
        output int          wlast_bad
    );
        int w;
        int nb;
        bit fire;
        data_bad = 0;
        wlast_bad = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_local_addr = la;
        cmd_ext_addr = ea;
        step();
        cmd_valid = 1'b0;
        chk("aw_valid", m_axi_awvalid, 1'b1);
        chk("aw_addr", m_axi_awaddr, ea);
        chk("aw_len_size_burst",
            {m_axi_awlen, m_axi_awsize, m_axi_awburst},
            {8'd7, 3'd2, 2'b01});
        chk("rd_ctrl_by_aw", data_mem_read_ctrl_by, 1'b1);
        // stall AW: no W beat may appear before the AW handshake
        for (int k = 0; k < 2; k++) begin
            if (m_axi_wvalid || !m_axi_awvalid) data_bad++;
            step();
        end
        m_axi_awready = 1'b1;
        step();
        m_axi_awready = 1'b0;
        nb = 0;
        w = 0;
        while (nb < stop_after && w < 64) begin
            m_axi_wready = toggle ? w[0] : 1'b1;
            #1;
            if (m_axi_wvalid) begin
                if (m_axi_wdata !== 32'(nb)) data_bad++;
                if (m_axi_wlast !== (nb == 7)) wlast_bad++;
                if (m_axi_wstrb !== 4'hF) data_bad++;
                if (!data_mem_read_ctrl_by) data_bad++;
            end else begin
                data_bad++;
            end
            fire = m_axi_wvalid && m_axi_wready;
            step();
            w++;
            if (fire) nb++;
        end
        m_axi_wready = 1'b0;
        chk("w_beats", nb, stop_after);
        if (stop_after == 8) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp = bresp;
            #1;
            chk("b_ready", m_axi_bready, 1'b1);
            step();
            m_axi_bvalid = 1'b0;
            m_axi_bresp = 2'b00;
            got_done = done;
            got_err = err;
            step();
        end
    endtask

    int cyc;
    bit gd;
    bit ge;
    int bb;
    int wb;
    int i0;
    int d0;
    int b0;

    initial begin
        cpu_rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_local_addr = 32'h0;
        cmd_ext_addr = 32'h0;
        m_axi_arready = 1'b1;
        m_axi_rdata = 32'h0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready = 1'b0;
        m_axi_bresp = 2'b00;
        m_axi_bvalid = 1'b0;
        for (int k = 0; k < 256; k++) dmem_pre[k] = 32'hDEAD_0000 + 32'(k);
        for (int k = 0; k < 8; k++) dmem_pre[8 + k] = 32'(k);
        repeat (2) @(posedge cpu_clk);
        #1;

        // reset values
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids",
            {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
             m_axi_rready, m_axi_bready}, 5'b0);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_ctrl_by",
            {data_mem_read_ctrl_by, data_mem_write_ctrl_by}, 2'b00);
        chk("rst_we", {inst_mem_write, data_mem_write}, 2'b00);
        chk("rst_addr", m_axi_araddr | m_axi_awaddr | dma_inst_mem_waddr, 32'h0);
        cpu_rst = 1'b0;
        step();

        // 1: inst refill, slave always ready
        i0 = iw_cnt;
        d0 = dw_cnt;
        run_read(2'd0, 32'h40, 32'h1000, 8, 7, -1, 1'b0, 1'b0,
                 8'hA0, cyc, gd, ge, bb);
        chk("t1_done_cycle", cyc, 10);
        chk("t1_done_err", {gd, ge}, 2'b10);
        chk("t1_iwrites", iw_cnt - i0, 8);
        chk("t1_no_dwrites", dw_cnt - d0, 0);
        chk("t1_imem_first", imem_log[16], 32'hA0);
        chk("t1_imem_mid", imem_log[19], 32'hA3);
        chk("t1_imem_last", imem_log[23], 32'hA7);
        chk("t1_idle_after", {cmd_ready, done}, 2'b10);

        // 2: data refill with rvalid gaps
        i0 = iw_cnt;
        d0 = dw_cnt;
        b0 = bad_cnt;
        run_read(2'd1, 32'h80, 32'h2000, 8, 7, -1, 1'b1, 1'b0,
                 8'hB0, cyc, gd, ge, bb);
        chk("t2_done_err", {gd, ge}, 2'b10);
        chk("t2_dwrites", dw_cnt - d0, 8);
        chk("t2_no_iwrites", iw_cnt - i0, 0);
        chk("t2_gap_ctrl", bb, 0);
        chk("t2_bad_writes", bad_cnt - b0, 0);
        chk("t2_dmem_0", dmem_log[32], 32'hB0);
        chk("t2_dmem_7", dmem_log[39], 32'hB7);
        chk("t2_ctrl_released", data_mem_write_ctrl_by, 1'b0);

        // 3: writeback, wready toggling
        run_wb(32'h20, 32'h3000, 1'b1, 2'b00, 8, gd, ge, bb, wb);
        chk("t3_wdata_order", bb, 0);
        chk("t3_wlast", wb, 0);
        chk("t3_done_err", {gd, ge}, 2'b10);
        chk("t3_rd_ctrl_released", data_mem_read_ctrl_by, 1'b0);

        // 4a: SLVERR on beat 3, full burst still consumed
        d0 = dw_cnt;
        run_read(2'd1, 32'hC0, 32'h5000, 8, 7, 3, 1'b0, 1'b0,
                 8'hE0, cyc, gd, ge, bb);
        chk("t4_slverr_done_err", {gd, ge}, 2'b11);
        chk("t4_slverr_writes", dw_cnt - d0, 8);
        chk("t4_slverr_last", dmem_log[55], 32'hE7);

        // 4b: DECERR on write response
        run_wb(32'h20, 32'h6000, 1'b0, 2'b11, 8, gd, ge, bb, wb);
        chk("t4_decerr_data", bb + wb, 0);
        chk("t4_decerr_done_err", {gd, ge}, 2'b11);

        // 5: early rlast on beat 5 with a command poked while busy
        i0 = iw_cnt;
        run_read(2'd0, 32'h200, 32'h7000, 6, 5, -1, 1'b0, 1'b1,
                 8'hD0, cyc, gd, ge, bb);
        chk("t5_done_err", {gd, ge}, 2'b11);
        chk("t5_iwrites", iw_cnt - i0, 6);
        chk("t5_busy_ignored", bb, 0);
        step();
        chk("t5_no_wb_started", {m_axi_awvalid, cmd_ready}, 2'b01);

        // reserved opcode completes at once with an error
        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        step();
        cmd_valid = 1'b0;
        chk("op3_done_err", {done, err}, 2'b11);
        step();
        chk("op3_idle", {done, cmd_ready}, 2'b01);

        // 6: reset in the middle of the W phase
        run_wb(32'h20, 32'h8000, 1'b0, 2'b00, 3, gd, ge, bb, wb);
        chk("t6_in_w", m_axi_wvalid, 1'b1);
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        chk("t6_rst_valids", {m_axi_wvalid, m_axi_awvalid}, 2'b00);
        chk("t6_rst_ctrl", data_mem_read_ctrl_by, 1'b0);
        chk("t6_rst_ready", cmd_ready, 1'b1);
        cpu_rst = 1'b0;
        step();
        i0 = iw_cnt;
        run_read(2'd0, 32'h100, 32'h4000, 8, 7, -1, 1'b0, 1'b0,
                 8'hC0, cyc, gd, ge, bb);
        chk("t6_refill_done_err", {gd, ge}, 2'b10);
        chk("t6_refill_writes", iw_cnt - i0, 8);
        chk("t6_refill_data", imem_log[71], 32'hC7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
